// File: rtl/cprv_regfile_mp.sv
// Multi-port integer register file with write-first bypass and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module cprv_regfile_mp #(
    parameter int unsigned  DATA_WIDTH    = 64,
    parameter int unsigned  REGADDR_WIDTH = 5,
    parameter int unsigned  NUM_RD        = 2,
    parameter int unsigned  NUM_WR        = 1,
    parameter bit           ZERO_REG      = 1'b1,
    localparam int unsigned NREG          = 2**REGADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_RD*REGADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]               rd_busy_o,
    input  logic [NUM_WR-1:0]               wr_en_i,
    input  logic [NUM_WR*REGADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data_i,
    input  logic                            iss_en_i,
    input  logic [REGADDR_WIDTH-1:0]        iss_addr_i,
    input  logic                            flush_i,
    output logic [NREG-1:0]                 busy_vec_o
);

    logic [DATA_WIDTH-1:0] mem_q [NREG];
    logic [DATA_WIDTH-1:0] mem_d [NREG];
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_d;
    logic [NREG-1:0]       clr;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic                  clr_w;
            logic                  set_w;
            logic [DATA_WIDTH-1:0] wdata_w;

            // Ascending scan so the highest-index matching write port wins.
            always_comb begin
                clr_w   = 1'b0;
                wdata_w = mem_q[gi];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] &&
                        wr_addr_i[j*REGADDR_WIDTH +: REGADDR_WIDTH] == REGADDR_WIDTH'(gi)) begin
                        clr_w   = 1'b1;
                        wdata_w = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign set_w   = iss_en_i && (iss_addr_i == REGADDR_WIDTH'(gi));
            assign clr[gi] = clr_w;

            if (ZERO_REG && gi == 0) begin : g_zero
                assign mem_d[gi]  = '0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_norm
                assign mem_d[gi]  = wdata_w;
                // A new producer replaces the retiring one when both hit together.
                assign busy_d[gi] = flush_i ? 1'b0 :
                                    set_w   ? 1'b1 :
                                    clr_w   ? 1'b0 : busy_q[gi];
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [REGADDR_WIDTH-1:0] addr_w;
            logic [DATA_WIDTH-1:0]    data_w;

            assign addr_w = rd_addr_i[gi*REGADDR_WIDTH +: REGADDR_WIDTH];

            always_comb begin
                data_w = mem_q[addr_w];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] &&
                        wr_addr_i[j*REGADDR_WIDTH +: REGADDR_WIDTH] == addr_w) begin
                        data_w = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (ZERO_REG && addr_w == '0) begin
                    data_w = '0;
                end
            end

            assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = data_w;
            // A register retiring this cycle is already visible through the bypass.
            assign rd_busy_o[gi] = ~flush_i & busy_q[addr_w] & ~clr[addr_w];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_cprv_regfile_mp.sv
// Randomized scoreboard bench: two register files (x0 hardwired and not) share
// stimulus; a reference model predicts outputs, a monitor compares each cycle.
module tb_cprv_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NW-1:0]     wr_en = '0;
    logic [NW*AW-1:0]  wr_addr = '0;
    logic [NW*DW-1:0]  wr_data = '0;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic              flush = 1'b0;

    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     rd_busy_a, rd_busy_b;
    logic [31:0]       busy_vec_a, busy_vec_b;

    cprv_regfile_mp #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                      .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
        .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush), .busy_vec_o(busy_vec_a));

    cprv_regfile_mp #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                      .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush), .busy_vec_o(busy_vec_b));

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      tag;
        logic [NR*DW-1:0] rd_data_a;
        logic [NR*DW-1:0] rd_data_b;
        logic [NR-1:0]    rd_busy_a;
        logic [NR-1:0]    rd_busy_b;
        logic [31:0]      busy_vec_a;
        logic [31:0]      busy_vec_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_step = 0;

    // Reference state: index 0 models the x0-hardwired file, index 1 the plain one.
    logic [DW-1:0] m_mem [2][32];
    logic [31:0]   m_busy [2];

    // Staged stimulus, applied just after the next rising edge.
    logic              s_rst_n = 1'b0;
    logic [NR*AW-1:0]  s_rd_addr = '0;
    logic [NW-1:0]     s_wr_en = '0;
    logic [NW*AW-1:0]  s_wr_addr = '0;
    logic [NW*DW-1:0]  s_wr_data = '0;
    logic              s_iss_en = 1'b0;
    logic [AW-1:0]     s_iss_addr = '0;
    logic              s_flush = 1'b0;

    function automatic logic [DW-1:0] mdl_read(int d, logic [AW-1:0] a);
        if (d == 0 && a == 0) return '0;
        for (int j = NW - 1; j >= 0; j--) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*DW +: DW];
        end
        return m_mem[d][a];
    endfunction

    function automatic bit mdl_written(logic [AW-1:0] a);
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle();
        s_rst_n = 1'b1; s_wr_en = '0; s_iss_en = 1'b0; s_flush = 1'b0;
    endtask

    task automatic rd(int i, logic [AW-1:0] a);
        s_rd_addr[i*AW +: AW] = a;
    endtask

    task automatic wr(int j, logic [AW-1:0] a, logic [DW-1:0] v);
        s_wr_en[j] = 1'b1; s_wr_addr[j*AW +: AW] = a; s_wr_data[j*DW +: DW] = v;
    endtask

    task automatic step();
        exp_t          e;
        logic [DW-1:0] rdv [2][NR];
        logic [NR-1:0] rbv [2];
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        rst_n = s_rst_n; rd_addr = s_rd_addr; wr_en = s_wr_en; wr_addr = s_wr_addr;
        wr_data = s_wr_data; iss_en = s_iss_en; iss_addr = s_iss_addr; flush = s_flush;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) m_mem[d][r] = '0;
                m_busy[d] = '0;
            end
            for (int i = 0; i < NR; i++) begin
                a = rd_addr[i*AW +: AW];
                rdv[d][i] = mdl_read(d, a);
                rbv[d][i] = !flush && m_busy[d][a] && !mdl_written(a);
            end
        end
        e.tag = 32'(n_step);
        e.rd_data_a = {rdv[0][3], rdv[0][2], rdv[0][1], rdv[0][0]};
        e.rd_data_b = {rdv[1][3], rdv[1][2], rdv[1][1], rdv[1][0]};
        e.rd_busy_a = rbv[0];
        e.rd_busy_b = rbv[1];
        e.busy_vec_a = m_busy[0];
        e.busy_vec_b = m_busy[1];
        exp_q.push_back(e);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] nb;
                nb = flush ? 32'h0 : m_busy[d];
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j]) begin
                        a = wr_addr[j*AW +: AW];
                        if (!(d == 0 && a == 0)) m_mem[d][a] = wr_data[j*DW +: DW];
                        if (!flush) nb[a] = 1'b0;
                    end
                end
                if (!flush && iss_en && !(d == 0 && iss_addr == 0)) nb[iss_addr] = 1'b1;
                m_busy[d] = nb;
            end
        end
        n_step++;
    endtask

    task automatic chk(string name, logic [31:0] tag, logic [NR*DW-1:0] act, logic [NR*DW-1:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s step=%0d got=%h want=%h", name, tag, act, want);
        end
    endtask

    // Monitor: outputs are combinational from state + inputs, so every cycle
    // presents a response; sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("step %0d rst_n=%b wr_en=%b iss=%b flush=%b rd_addr=%h", e.tag, rst_n, wr_en,
                         iss_en, flush, rd_addr);
                chk("rd_data_a", e.tag, rd_data_a, e.rd_data_a);
                chk("rd_data_b", e.tag, rd_data_b, e.rd_data_b);
                chk("rd_busy_a", e.tag, (NR*DW)'(rd_busy_a), (NR*DW)'(e.rd_busy_a));
                chk("rd_busy_b", e.tag, (NR*DW)'(rd_busy_b), (NR*DW)'(e.rd_busy_b));
                chk("busy_vec_a", e.tag, (NR*DW)'(busy_vec_a), (NR*DW)'(e.busy_vec_a));
                chk("busy_vec_b", e.tag, (NR*DW)'(busy_vec_b), (NR*DW)'(e.busy_vec_b));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog step=%0d", n_step);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cyc;
        // Reset held three cycles, then read x5 / x31.
        idle(); s_rst_n = 1'b0;
        rd(0, 5); rd(1, 31); rd(2, 0); rd(3, 1);
        repeat (3) step();
        idle(); step();
        // x7 write, readback, then async reset seen before any edge.
        idle(); wr(0, 7, 64'hDEAD); rd(0, 7); step();
        idle(); step();
        idle(); s_rst_n = 1'b0; step();
        idle(); step();
        // Write-first bypass then stored value.
        idle(); wr(0, 3, 64'h1234_5678_9ABC_DEF0); rd(0, 3); step();
        idle(); step();
        // x0 write + issue.
        idle(); wr(0, 0, '1); s_iss_en = 1'b1; s_iss_addr = 0; rd(0, 0); step();
        idle(); step();
        // Scoreboard lifecycle on x10.
        idle(); s_iss_en = 1'b1; s_iss_addr = 10; rd(1, 10); step();
        idle(); step();
        idle(); wr(1, 10, 64'h42); step();
        idle(); step();
        // Set and clear on x4 together: set wins.
        idle(); wr(0, 4, 64'h5); s_iss_en = 1'b1; s_iss_addr = 4; rd(2, 4); step();
        idle(); step();
        // Issue x8, x9 then flush, with a write committing in the flush cycle.
        idle(); s_iss_en = 1'b1; s_iss_addr = 8; rd(0, 8); rd(1, 9); step();
        idle(); s_iss_en = 1'b1; s_iss_addr = 9; step();
        idle(); s_flush = 1'b1; s_iss_en = 1'b1; s_iss_addr = 12; wr(0, 8, 64'h88); step();
        idle(); step();
        // Both write ports hit x12: port 1 wins.
        idle(); wr(0, 12, 64'h1); wr(1, 12, 64'h2); rd(3, 12); step();
        idle(); step();
        // Four independent reads.
        idle(); rd(0, 3); rd(1, 4); rd(2, 10); rd(3, 12); step();
        // Randomized traffic, addresses biased low to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int i = 0; i < NR; i++)
                rd(i, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)));
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) == 1)
                    wr(j, AW'($urandom_range(0, 15)), {$urandom, $urandom});
            s_iss_en = ($urandom_range(0, 2) == 0);
            s_iss_addr = AW'($urandom_range(0, 15));
            s_flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                s_rst_n = 1'b0; s_wr_en = '0;
            end
            step();
        end
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
